fb_fill_engine: RTL and testbench

FB_FILL_ENGINE -- requirements
Module: fb_fill_engine

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_sweep_ctr.sv | 38 +++
 rtl/fb_fill_engine.sv | 117 +++++++++++
 tb/tb_fb_fill_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: fill-engine state encoding, default widths and SRAM address width; FB_DOUBLE_BUF_EN adds a bank bit
package fb_pkg;
    localparam int FB_X_W    = 9;
    localparam int FB_Y_W    = 9;
    localparam int FB_DATA_W = 16;
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, NEXT, FIN} fb_state_t;
    function automatic int fb_addr_w(input int xw, input int yw);
`ifdef FB_DOUBLE_BUF_EN
        return xw + yw + 1;
`else
        return xw + yw;
`endif
    endfunction
endpackage

// File: rtl/fb_sweep_ctr.sv
// fb_sweep_ctr: y-fastest x/y sweep counter with clear, advance and last-pixel flag
module fb_sweep_ctr
    import fb_pkg::*;
#(
    parameter int X_W   = FB_X_W,
    parameter int Y_W   = FB_Y_W,
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           y_wrap;
    assign y_wrap = y_q == Y_W'(Y_MAX);
    assign last   = y_wrap && x_q == X_W'(X_MAX);
    assign x_o    = x_q;
    assign y_o    = y_q;
    always_comb begin
        x_d = clear ? '0 : (advance && y_wrap) ? x_q + X_W'(1) : x_q;
        y_d = clear ? '0 : advance ? (y_wrap ? '0 : y_q + Y_W'(1)) : y_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: sweeps the frame writing fg/bg per inside-test, displays from SRAM when idle; FB_DOUBLE_BUF_EN enables double buffering
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int X_W       = FB_X_W,
    parameter int Y_W       = FB_Y_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int X_MAX     = 319,
    parameter int Y_MAX     = 239,
    parameter int TEST_LAT  = 2,
    parameter int WE_CYCLES = 4,
    localparam int ADDR_W   = fb_addr_w(X_W, Y_W)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [DATA_W-1:0] fg_color,
    input  logic [DATA_W-1:0] bg_color,
    output logic [X_W-1:0]    test_x,
    output logic [Y_W-1:0]    test_y,
    input  logic              test_in,
    input  logic [X_W-1:0]    px,
    input  logic [Y_W-1:0]    py,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    fb_state_t         state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic [DATA_W-1:0] fg_q, bg_q, wdata_q, pix_out_q;
    logic              pix_valid_q, clr, adv, last, set_end, wr_end, idle_stay;

    fb_sweep_ctr #(.X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_sweep (
        .clk_i(CLOCK_50), .rst_n_i(RESET_N), .clear(clr), .advance(adv),
        .x_o(test_x), .y_o(test_y), .last(last)
    );

    assign set_end   = timer_q == 8'(TEST_LAT - 1);
    assign wr_end    = timer_q == 8'(WE_CYCLES - 1);
    assign idle_stay = state_q == IDLE && state_d == IDLE;
    assign busy      = state_q != IDLE;
    assign done      = state_q == FIN;
    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign SRAM_WE_N = state_q != WRITE;
    assign SRAM_OE_N = busy;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    // data stays on the bus through NEXT so it is stable past the WE_N rising edge
    assign SRAM_DQ   = (state_q == WRITE || state_q == NEXT) ? wdata_q : 'z;

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = start ? SETUP : IDLE;
                clr     = start;
            end
            SETUP: begin
                state_d = set_end ? WRITE : SETUP;
                timer_d = set_end ? '0 : timer_q + 8'd1;
            end
            WRITE: begin
                state_d = wr_end ? NEXT : WRITE;
                timer_d = wr_end ? '0 : timer_q + 8'd1;
            end
            NEXT: begin
                state_d = last ? FIN : SETUP;
                adv     = ~last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            wdata_q     <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fg_q        <= clr ? fg_color : fg_q;
            bg_q        <= clr ? bg_color : bg_q;
            wdata_q     <= (state_q == SETUP && set_end) ? (test_in ? fg_q : bg_q) : wdata_q;
            pix_out_q   <= idle_stay ? SRAM_DQ : '0;
            pix_valid_q <= idle_stay;
        end
    end

`ifdef FB_DOUBLE_BUF_EN
    logic front_q;
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) front_q <= 1'b0;
        else          front_q <= (state_q == FIN) ? ~front_q : front_q;
    end
    assign SRAM_ADDR = busy ? {~front_q, test_x, test_y} : {front_q, px, py};
`else
    assign SRAM_ADDR = busy ? {test_x, test_y} : {px, py};
`endif
endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: SRAM model plus fill-order reference model for fb_fill_engine
module tb_fb_fill_engine;
    localparam int X_W = 9, Y_W = 9, DATA_W = 16;
    localparam int X_MAX = 3, Y_MAX = 2, TEST_LAT = 2, WE_CYCLES = 4;
`ifdef FB_DOUBLE_BUF_EN
    localparam int DBL = 1;
`else
    localparam int DBL = 0;
`endif
    localparam int ADDR_W  = X_W + Y_W + DBL;
    localparam int NPIX    = (X_MAX + 1) * (Y_MAX + 1);
    localparam int PIX_CYC = TEST_LAT + WE_CYCLES + 1;

    logic clk = 0, rst_n = 0, start = 0, test_in;
    logic [15:0] fg = 0, bg = 0, pix_out;
    logic [X_W-1:0] test_x, px = 0;
    logic [Y_W-1:0] test_y, py = 0;
    logic pix_valid, busy, done, we_n, oe_n, ce_n, ub_n, lb_n;
    logic [ADDR_W-1:0] addr;
    wire  [15:0] dq;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic drive_en = 1, we_prev = 1;
    logic [ADDR_W+15:0] wlog[$];
    logic [NPIX-1:0] ins = '1;
    logic [15:0] img [NPIX];
    int n_cmp = 0, n_err = 0, done_cnt = 0, blank_err = 0, front_m = 0;

    typedef struct { int px; int py; logic [15:0] exp; } vec_t;
    vec_t tab [6];

    fb_fill_engine #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
                     .TEST_LAT(TEST_LAT), .WE_CYCLES(WE_CYCLES)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .fg_color(fg), .bg_color(bg),
        .test_x(test_x), .test_y(test_y), .test_in(test_in), .px(px), .py(py),
        .pix_out(pix_out), .pix_valid(pix_valid), .busy(busy), .done(done),
        .SRAM_ADDR(addr), .SRAM_DQ(dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // external inside-test: a lookup of the current sweep coordinate
    always_comb test_in = (int'(test_x) <= X_MAX && int'(test_y) <= Y_MAX) ?
                          ins[int'(test_x) * (Y_MAX + 1) + int'(test_y)] : 1'b0;
    assign dq = (drive_en && !oe_n && we_n) ? mem[addr] : 'z;

    always @(negedge clk) begin
        if (!we_n) mem[addr] = dq;
        if (!we_n && we_prev) wlog.push_back({addr, dq});
        we_prev = we_n;
        if (done) done_cnt++;
        if (busy && (pix_valid || pix_out != 0)) blank_err++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_chk(input int x, input int y, input logic [15:0] exp);
        @(posedge clk); #1;
        px = X_W'(x);
        py = Y_W'(y);
        #1;
        chk("disp_addr", 64'(addr), 64'((DBL * front_m << (X_W + Y_W)) | (x << Y_W) | y));
        @(posedge clk); #1;
        chk("disp_pix", 64'(pix_out), 64'(exp));
        chk("disp_valid", 64'(pix_valid), 64'd1);
    endtask

    task automatic fill(input logic [15:0] f, input logic [15:0] b, input int extra);
        int cyc, d0;
        logic [ADDR_W-1:0] ea;
        wlog.delete();
        d0 = done_cnt;
        blank_err = 0;
        fg = f;
        bg = b;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        fg = ~f;
        bg = ~b;
        chk("busy_rise", 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == extra);
        end
        chk("done_latency", 64'(cyc), 64'(NPIX * PIX_CYC));
        chk("done_busy", 64'(busy), 64'd1);
        start = 1;
        @(posedge clk); #1 start = 0;
        chk("fin_to_idle", 64'(busy), 64'd0);
        chk("idle1_valid", 64'(pix_valid), 64'd0);
        @(posedge clk); #1;
        chk("fin_start_ignored", 64'(busy), 64'd0);
        chk("idle2_valid", 64'(pix_valid), 64'd1);
        chk("one_done", 64'(done_cnt - d0), 64'd1);
        chk("blank_during_fill", 64'(blank_err), 64'd0);
        chk("write_count", 64'(wlog.size()), 64'(NPIX));
        for (int x = 0; x <= X_MAX; x++)
            for (int y = 0; y <= Y_MAX; y++) begin
                int k;
                k = x * (Y_MAX + 1) + y;
                img[k] = ins[k] ? f : b;
                ea = ADDR_W'((DBL * (1 - front_m) << (X_W + Y_W)) | (x << Y_W) | y);
                chk("write", k < wlog.size() ? 64'(wlog[k]) : 64'hDEAD, 64'({ea, img[k]}));
            end
        if (DBL == 1) front_m = 1 - front_m;
    endtask

    initial begin
        tab[0] = '{0, 0, 16'hBEEF};
        tab[1] = '{1, 0, 16'h1234};
        tab[2] = '{1, 2, 16'h1234};
        tab[3] = '{2, 1, 16'hBEEF};
        tab[4] = '{3, 2, 16'h1234};
        tab[5] = '{5, 7, 16'h5A5A};
        mem[(2 << Y_W) | 1] = 16'h0C0D;
        mem[(5 << Y_W) | 7] = 16'h5A5A;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_pix", 64'(pix_out), 64'd0);
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("tied_ctrl", 64'({ce_n, ub_n, lb_n}), 64'd0);
        px = 2;
        py = 1;
        rst_n = 1;
        #1;
        chk("idle_addr", 64'(addr), 64'((2 << Y_W) | 1));
        chk("first_idle_valid", 64'(pix_valid), 64'd0);
        chk("idle_oe_n", 64'(oe_n), 64'd0);
        @(posedge clk); #1;
        chk("second_idle_valid", 64'(pix_valid), 64'd1);
        chk("second_idle_pix", 64'(pix_out), 64'h0C0D);

        ins = '1;
        fill(16'hA5A5, 16'h0000, -1);
        for (int k = 0; k < NPIX; k++) ins[k] = ((k / (Y_MAX + 1)) % 2) == 1;
        fill(16'h1234, 16'hBEEF, 20);
        foreach (tab[i]) read_chk(tab[i].px, tab[i].py, tab[i].exp);

        repeat (3) begin
            ins = NPIX'($urandom);
            fill(16'($urandom), 16'($urandom), -1);
            for (int x = 0; x <= X_MAX; x++)
                for (int y = 0; y <= Y_MAX; y++) read_chk(x, y, img[x * (Y_MAX + 1) + y]);
        end

        begin
            int cyc, d0;
            d0 = done_cnt;
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1 start = 0;
            cyc = 0;
            while (cyc < 4 * PIX_CYC + TEST_LAT + 1) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("px5_write_we", 64'(we_n), 64'd0);
            drive_en = 0;
            rst_n = 0;
            @(posedge clk); #1;
            chk("mid_rst_we_n", 64'(we_n), 64'd1);
            n_cmp++;
            if (dq !== 16'hzzzz) begin
                n_err++;
                $display("FAIL mid_rst_dq: got %h expected zzzz", dq);
            end
            chk("mid_rst_busy", 64'(busy), 64'd0);
            chk("mid_rst_done", 64'(done), 64'd0);
            front_m = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            drive_en = 1;
            repeat (100) @(posedge clk);
            #1;
            chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
            chk("idle_after_rst", 64'(busy), 64'd0);
        end

        ins = NPIX'($urandom);
        fill(16'($urandom), 16'($urandom), 40);
        for (int x = 0; x <= X_MAX; x++)
            for (int y = 0; y <= Y_MAX; y++) read_chk(x, y, img[x * (Y_MAX + 1) + y]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
